// File: rtl/reg_bank_reader_if.sv
// rtl/reg_bank_reader_if.sv - read request/response handshake bundle for the register bank
interface reg_bank_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/reg_bank_reader.sv
// rtl/reg_bank_reader.sv - control register bank with registered read responder
module reg_bank_reader #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 3,
    parameter int                NUM_REGS = 4,
    parameter logic [DATA_W-1:0] RST_REG0 = 32'h8080_8100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    reg_bank_reader_if.slave  bus,
    output logic [15:0]       rd_count
);
    localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t       state_q;
    slot_state_t       state_d;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              req_ready_c;
    logic              accept;
    logic              rd_in_range;
    logic              wr_in_range;

    assign rd_in_range   = (bus.req_addr < NUM_REGS_A);
    assign wr_in_range   = (wr_addr < NUM_REGS_A);
    assign accept        = bus.req_valid & req_ready_c;

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_q == SLOT_FULL);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // Register bank: reset pattern, then in-range writes; out-of-range writes are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == 0) ? RST_REG0 : '0;
            end
        end else if (wr_en && wr_in_range) begin
            regs[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Response slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next-state and request-ready; the slot can refill in the same cycle it drains
    always_comb begin
        state_d     = state_q;
        req_ready_c = 1'b1;
        case (state_q)
            SLOT_EMPTY: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                req_ready_c = bus.rsp_ready;
                if (bus.rsp_ready && !bus.req_valid) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: begin
                state_d     = SLOT_EMPTY;
                req_ready_c = 1'b1;
            end
        endcase
    end

    // Response payload captured on accept; the bank is sampled before any same-edge write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            rsp_data_q <= rd_in_range ? regs[bus.req_addr[IDX_W-1:0]] : '0;
            rsp_err_q  <= !rd_in_range;
        end
    end

    // Accepted-request counter, errored requests included, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else if (accept) begin
            rd_count <= rd_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_reg_bank_reader.sv
// tb/tb_reg_bank_reader.sv - directed self-checking bench for reg_bank_reader
module tb_reg_bank_reader;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] rd_count;

    int n_compared;
    int n_mismatched;

    reg_bank_reader_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    reg_bank_reader #(
        .DATA_W  (32),
        .ADDR_W  (3),
        .NUM_REGS(4),
        .RST_REG0(32'h8080_8100)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .bus     (bus),
        .rd_count(rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [2:0] a,
                           input logic [31:0] exp_data, input logic exp_err);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_data"},  bus.rsp_data, exp_data);
        chk({tag, "_err"},   32'(bus.rsp_err), 32'(exp_err));
    endtask

    initial begin
        n_compared    = 0;
        n_mismatched  = 0;
        rst_n         = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;

        step();
        step();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data",  bus.rsp_data, 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        chk("rst_rd_count",  32'(rd_count), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;
        step();

        do_read("rd0_reset", 3'd0, 32'h8080_8100, 1'b0);
        do_read("rd1_reset", 3'd1, 32'h0000_0000, 1'b0);
        chk("count_after_2", 32'(rd_count), 32'd2);

        do_write(3'd2, 32'hDEAD_BEEF);
        do_read("rd2_written", 3'd2, 32'hDEAD_BEEF, 1'b0);

        wr_en         = 1'b1;
        wr_addr       = 3'd1;
        wr_data       = 32'h0000_1234;
        bus.req_valid = 1'b1;
        bus.req_addr  = 3'd1;
        bus.rsp_ready = 1'b1;
        step();
        wr_en         = 1'b0;
        bus.req_valid = 1'b0;
        chk("collide_old_data", bus.rsp_data, 32'h0000_0000);
        do_read("collide_new", 3'd1, 32'h0000_1234, 1'b0);
        chk("count_after_5", 32'(rd_count), 32'd5);

        do_read("rd5_err", 3'd5, 32'h0, 1'b1);
        chk("count_after_err", 32'(rd_count), 32'd6);
        do_write(3'd6, 32'hFFFF_FFFF);
        do_read("post_oor_r0", 3'd0, 32'h8080_8100, 1'b0);
        do_read("post_oor_r1", 3'd1, 32'h0000_1234, 1'b0);
        do_read("post_oor_r2", 3'd2, 32'hDEAD_BEEF, 1'b0);
        do_read("post_oor_r3", 3'd3, 32'h0000_0000, 1'b0);
        chk("count_after_10", 32'(rd_count), 32'd10);

        step();
        chk("drained_valid", 32'(bus.rsp_valid), 32'd0);

        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 3'd2;
        step();
        bus.req_addr  = 3'd0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_data",  bus.rsp_data, 32'hDEAD_BEEF);
            chk("bp_rsp_err",   32'(bus.rsp_err), 32'd0);
            chk("bp_rd_count",  32'(rd_count), 32'd11);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("release_req_ready", 32'(bus.req_ready), 32'd1);
        step();
        chk("b2b_first_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_first_data",  bus.rsp_data, 32'h8080_8100);
        bus.req_addr = 3'd1;
        step();
        chk("b2b_second_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_second_data",  bus.rsp_data, 32'h0000_1234);
        bus.req_valid = 1'b0;
        step();
        chk("b2b_drained", 32'(bus.rsp_valid), 32'd0);
        chk("count_after_bp", 32'(rd_count), 32'd13);

        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 3'd2;
        step();
        bus.req_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_data",  bus.rsp_data, 32'd0);
        chk("midrst_count", 32'(rd_count), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        do_read("rst2_r1", 3'd1, 32'h0000_0000, 1'b0);
        do_read("rst2_r2", 3'd2, 32'h0000_0000, 1'b0);
        do_read("rst2_r0", 3'd0, 32'h8080_8100, 1'b0);
        chk("count_after_rst2", 32'(rd_count), 32'd3);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
